wr_lane_serializer: RTL and testbench

Write-domain front end that takes up to M_WRITERS words per cycle from parallel writer lanes and serializes them into the single-word write port of a 1-wide async FIFO. It absorbs one batch at a time into a staging register set and drains it one word per cycle in ascending lane order, honouring FIFO back-pressure. It keeps accept, word and drop statistics for end-of-run reporting.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/lsb_prio_enc.sv | 29 ++
 rtl/wr_lane_serializer.sv | 132 +++++++++++++
 tb/tb_wr_lane_serializer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the write-side lane serializer.
// The saturating increment works on a wide carrier so any counter width up to 64 can use it.
package fifo_pkg;

  localparam int unsigned CNT_W_DEFAULT = 32;
  localparam int unsigned CNT_MAX_W     = 64;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } lane_state_e;

  // Increment 'value' unless it already holds the all-ones pattern of a 'width'-bit counter.
  function automatic logic [CNT_MAX_W-1:0] sat_inc(
    input logic [CNT_MAX_W-1:0] value,
    input int unsigned          width
  );
    logic [CNT_MAX_W-1:0] maxVal;
    maxVal = (width >= CNT_MAX_W) ? {CNT_MAX_W{1'b1}}
                                  : ((64'd1 << width) - 64'd1);
    sat_inc = (value >= maxVal) ? maxVal : (value + 64'd1);
  endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot grant, binary index, any-set and exactly-one-set flags.
module lsb_prio_enc #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic             single_o
);

  // Scanning from the top down lets the lowest set bit win the last assignment.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
      end
    end
  end

  assign any_o    = |req_i;
  assign single_o = any_o & ((req_i & ~grant_o) == '0);

endmodule

// File: rtl/wr_lane_serializer.sv
// Absorbs one batch of parallel writer lanes into staging and drains it one word per cycle
// into a 1-wide FIFO write port in ascending lane order, with accept/word/drop statistics.
module wr_lane_serializer
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned M_WRITERS = 4,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
  input  logic                       i_wr_clk,
  input  logic                       i_wr_rstn,
  input  logic [M_WRITERS-1:0]       i_wr_en,
  input  logic [M_WRITERS*WIDTH-1:0] i_wr_data,
  output logic                       o_wr_ready,
  input  logic                       i_fifo_full,
  output logic                       o_fifo_wr_en,
  output logic [WIDTH-1:0]           o_fifo_wr_data,
  output logic                       o_busy,
  output logic                       o_overflow,
  output logic [CNT_W-1:0]           o_batch_cnt,
  output logic [CNT_W-1:0]           o_word_cnt,
  output logic [CNT_W-1:0]           o_drop_cnt
);

  localparam int unsigned IDX_W = (M_WRITERS > 1) ? $clog2(M_WRITERS) : 1;

  logic [M_WRITERS-1:0]            pend_q, pend_d;
  logic [M_WRITERS-1:0][WIDTH-1:0] stage_q, stage_d;
  lane_state_e                     state_q, state_d;
  logic                            overflow_q, overflow_d;
  logic [CNT_W-1:0]                batchCnt_q, batchCnt_d;
  logic [CNT_W-1:0]                wordCnt_q, wordCnt_d;
  logic [CNT_W-1:0]                dropCnt_q, dropCnt_d;

  logic [M_WRITERS-1:0] selGrant;
  logic [IDX_W-1:0]     selIdx;
  logic                 pendAny;
  logic                 pendSingle;
  logic                 emit;
  logic                 lastFire;
  logic                 ready;
  logic                 batchReq;
  logic                 accept;
  logic                 drop;

  function automatic logic [CNT_W-1:0] incSat(input logic [CNT_W-1:0] v);
    logic [CNT_MAX_W-1:0] wide;
    wide = sat_inc(CNT_MAX_W'(v), CNT_W);
    return wide[CNT_W-1:0];
  endfunction

  lsb_prio_enc #(
    .N     (M_WRITERS),
    .IDX_W (IDX_W)
  ) u_sel (
    .req_i    (pend_q),
    .grant_o  (selGrant),
    .idx_o    (selIdx),
    .any_o    (pendAny),
    .single_o (pendSingle)
  );

  // Ready looks through the final emit so back-to-back batches run at full rate.
  assign emit     = pendAny & ~i_fifo_full;
  assign lastFire = pendSingle & emit;
  assign ready    = ~pendAny | lastFire;
  assign batchReq = |i_wr_en;
  assign accept   = batchReq & ready;
  assign drop     = batchReq & ~ready;

  always_comb begin
    pend_d     = pend_q;
    stage_d    = stage_q;
    overflow_d = overflow_q;
    batchCnt_d = batchCnt_q;
    wordCnt_d  = wordCnt_q;
    dropCnt_d  = dropCnt_q;

    if (emit) begin
      pend_d    = pend_q & ~selGrant;
      wordCnt_d = incSat(wordCnt_q);
    end

    // A new load overrides the clear of the final pending lane.
    if (accept) begin
      pend_d     = i_wr_en;
      batchCnt_d = incSat(batchCnt_q);
      for (int k = 0; k < M_WRITERS; k++) begin
        if (i_wr_en[k]) begin
          stage_d[k] = i_wr_data[k*WIDTH +: WIDTH];
        end
      end
    end

    if (drop) begin
      dropCnt_d  = incSat(dropCnt_q);
      overflow_d = 1'b1;
    end

    state_d = (pend_d != '0) ? S_DRAIN : S_IDLE;
  end

  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn) begin
      pend_q     <= '0;
      stage_q    <= '0;
      state_q    <= S_IDLE;
      overflow_q <= 1'b0;
      batchCnt_q <= '0;
      wordCnt_q  <= '0;
      dropCnt_q  <= '0;
    end else begin
      pend_q     <= pend_d;
      stage_q    <= stage_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
      batchCnt_q <= batchCnt_d;
      wordCnt_q  <= wordCnt_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  assign o_wr_ready     = ready;
  assign o_fifo_wr_en   = emit;
  assign o_fifo_wr_data = pendAny ? stage_q[selIdx] : '0;
  assign o_busy         = (state_q == S_DRAIN);
  assign o_overflow     = overflow_q;
  assign o_batch_cnt    = batchCnt_q;
  assign o_word_cnt     = wordCnt_q;
  assign o_drop_cnt     = dropCnt_q;

endmodule

// File: tb/tb_wr_lane_serializer.sv
// Directed bench for wr_lane_serializer: expected FIFO words (with their cycle) go into a queue,
// and a negedge monitor pops and compares every strobe the DUT raises.
module tb_wr_lane_serializer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned M     = 4;
  localparam int unsigned CW    = 32;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
  } expEntry_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [M-1:0]      wrEn = '0;
  logic [M*WIDTH-1:0] wrData = '0;
  logic              fifoFull = 1'b0;
  logic              wrReady;
  logic              fifoWrEn;
  logic [WIDTH-1:0]  fifoWrData;
  logic              busy;
  logic              overflow;
  logic [CW-1:0]     batchCnt;
  logic [CW-1:0]     wordCnt;
  logic [CW-1:0]     dropCnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n;
  int expBatch = 0;
  int expWord  = 0;
  int expDrop  = 0;
  int expOvf   = 0;

  expEntry_t expQ[$];
  expEntry_t monItem;

  wr_lane_serializer #(
    .WIDTH     (WIDTH),
    .M_WRITERS (M),
    .CNT_W     (CW)
  ) dut (
    .i_wr_clk       (clk),
    .i_wr_rstn      (rstn),
    .i_wr_en        (wrEn),
    .i_wr_data      (wrData),
    .o_wr_ready     (wrReady),
    .i_fifo_full    (fifoFull),
    .o_fifo_wr_en   (fifoWrEn),
    .o_fifo_wr_data (fifoWrData),
    .o_busy         (busy),
    .o_overflow     (overflow),
    .o_batch_cnt    (batchCnt),
    .o_word_cnt     (wordCnt),
    .o_drop_cnt     (dropCnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe must match the head of the expected queue in both data and cycle.
  always @(negedge clk) begin
    if (fifoWrEn) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write actual=%0h@%0d required=none", fifoWrData, cyc);
      end else begin
        monItem = expQ.pop_front();
        if (fifoWrData !== monItem.data || cyc != monItem.cyc) begin
          errors++;
          $display("[TB] FAIL fifo_write actual=%0h@%0d required=%0h@%0d",
                   fifoWrData, cyc, monItem.data, monItem.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [M-1:0] en, input logic [M*WIDTH-1:0] data,
                               input logic full);
    wrEn     = en;
    wrData   = data;
    fifoFull = full;
  endtask

  task automatic pushExp(input logic [WIDTH-1:0] data, input int c);
    expEntry_t e;
    e.data = data;
    e.cyc  = c;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_batch_cnt"}, batchCnt, expBatch);
    checkOutput({tag, "_word_cnt"}, wordCnt, expWord);
    checkOutput({tag, "_drop_cnt"}, dropCnt, expDrop);
    checkOutput({tag, "_overflow"}, {31'd0, overflow}, expOvf);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ready"}, {31'd0, wrReady}, 1);
    checkOutput({tag, "_wr_en"}, {31'd0, fifoWrEn}, 0);
    checkOutput({tag, "_wr_data"}, {24'd0, fifoWrData}, 0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    // Reset held with random lane activity.
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'($urandom), $urandom, 1'($urandom));
      @(negedge clk);
      checkIdleOutputs("rst_hold");
      checkCounters("rst_hold");
    end
    tick();
    applyStimulus('0, '0, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    checkIdleOutputs("rst_release");
    checkCounters("rst_release");

    // Sparse batch 1011.
    tick();
    n = cyc;
    applyStimulus(4'b1011, 32'h44332211, 1'b0);
    pushExp(8'h11, n + 1);
    pushExp(8'h22, n + 2);
    pushExp(8'h44, n + 3);
    expBatch++;
    @(negedge clk);
    checkOutput("sparse_ready_n", {31'd0, wrReady}, 1);
    tick();
    applyStimulus('0, '0, 1'b0);
    @(negedge clk);
    checkOutput("sparse_ready_n1", {31'd0, wrReady}, 0);
    checkOutput("sparse_busy_n1", {31'd0, busy}, 1);
    tick();
    @(negedge clk);
    checkOutput("sparse_ready_n2", {31'd0, wrReady}, 0);
    tick();
    @(negedge clk);
    checkOutput("sparse_ready_n3", {31'd0, wrReady}, 1);
    tick();
    @(negedge clk);
    expWord += 3;
    checkCounters("sparse");
    checkOutput("sparse_busy_end", {31'd0, busy}, 0);

    // Back-pressure during N+2..N+4.
    tick();
    n = cyc;
    applyStimulus(4'b1011, 32'h44332211, 1'b0);
    pushExp(8'h11, n + 1);
    pushExp(8'h22, n + 5);
    pushExp(8'h44, n + 6);
    expBatch++;
    tick();
    applyStimulus('0, '0, 1'b0);
    tick();
    fifoFull = 1'b1;
    @(negedge clk);
    checkOutput("bp_hold_wr_en", {31'd0, fifoWrEn}, 0);
    tick();
    @(negedge clk);
    checkOutput("bp_ready_full", {31'd0, wrReady}, 0);
    tick();
    tick();
    fifoFull = 1'b0;
    @(negedge clk);
    checkOutput("bp_ready_n5", {31'd0, wrReady}, 0);
    tick();
    @(negedge clk);
    checkOutput("bp_ready_n6", {31'd0, wrReady}, 1);
    tick();
    @(negedge clk);
    expWord += 3;
    checkCounters("backpressure");

    // Overflow: second batch while the first is still draining.
    tick();
    n = cyc;
    applyStimulus(4'b1011, 32'h44332211, 1'b0);
    pushExp(8'h11, n + 1);
    pushExp(8'h22, n + 2);
    pushExp(8'h44, n + 3);
    expBatch++;
    tick();
    applyStimulus(4'b0001, 32'h00000055, 1'b0);
    @(negedge clk);
    checkOutput("ovf_ready_n1", {31'd0, wrReady}, 0);
    tick();
    applyStimulus('0, '0, 1'b0);
    expDrop++;
    expOvf = 1;
    @(negedge clk);
    checkOutput("ovf_drop_cnt", dropCnt, expDrop);
    checkOutput("ovf_flag", {31'd0, overflow}, 1);
    tick();
    tick();
    @(negedge clk);
    expWord += 3;
    checkCounters("overflow");

    // Streaming single-lane batches every cycle.
    tick();
    n = cyc;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) tick();
      applyStimulus(4'b0001, {24'd0, 8'(i)}, 1'b0);
      pushExp(8'(i), n + i + 1);
      expBatch++;
      @(negedge clk);
      checkOutput("stream_ready", {31'd0, wrReady}, 1);
    end
    tick();
    applyStimulus('0, '0, 1'b0);
    tick();
    @(negedge clk);
    expWord += 100;
    checkCounters("stream");

    // Reset in the middle of a full drain.
    tick();
    n = cyc;
    applyStimulus(4'b1111, 32'hDDCCBBAA, 1'b0);
    pushExp(8'hAA, n + 1);
    expBatch++;
    tick();
    applyStimulus('0, '0, 1'b0);
    tick();
    rstn = 1'b0;
    expBatch = 0;
    expWord  = 0;
    expDrop  = 0;
    expOvf   = 0;
    @(negedge clk);
    checkIdleOutputs("middrain_rst");
    checkCounters("middrain_rst");
    tick();
    tick();
    rstn = 1'b1;
    @(negedge clk);
    checkIdleOutputs("middrain_release");
    tick();
    n = cyc;
    applyStimulus(4'b0100, 32'h11A52233, 1'b0);
    pushExp(8'hA5, n + 1);
    expBatch++;
    tick();
    applyStimulus('0, '0, 1'b0);
    @(negedge clk);
    checkOutput("after_rst_ready", {31'd0, wrReady}, 1);
    tick();
    @(negedge clk);
    expWord++;
    checkCounters("after_rst");
    checkOutput("after_rst_busy", {31'd0, busy}, 0);

    tick();
    tick();
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
